bank_read_responder: RTL and testbench

- Target-side servicer of one scratchpad bank's read-request FIFO (rFIFO). Sits between the rFIFO written by the bank access FSM and the bank SRAM read port.
- Pops requests and reads row {mat_s,row_s} from the bank.
- Responses are returned in request order:
  - Store requests (mat_t=0) go to the store/writeback port with a per-row byte address.
  - GEMM requests (mat_t=1 input, 2 weight, 3 psum) go to the systolic-array feed port.

---
 rtl/bank_read_responder.sv | 259 +++++++++++++++++++++++++
 tb/tb_bank_read_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_read_responder.sv
// -----------------------------------------------------------------------------
// bank_read_responder
//
// Target-side servicer of one scratchpad bank's read-request FIFO. Requests
// are popped from a show-ahead FIFO, the row {mat_s,row_s} is read from the
// bank SRAM, and the row data is returned strictly in request order:
//   mat_t = 0      -> store/writeback port, with a per-row byte address
//   mat_t = 1/2/3  -> systolic-array feed port (input / weight / psum)
//
// Requests are only issued while a response-queue slot is guaranteed for them
// (in-flight reads + queued responses < Q_DEPTH), so backpressure on either
// output port throttles issue without any combinational path from the ready
// inputs to rFIFO_REN.
//
// Optional feature: define BANK_RD_PERF_EN to build the perf_reads /
// perf_stalls counters. Without it both ports are tied to 0.
//
// Parameters:
//   BANK_NUM  bank index (informational)
//   READ_LAT  SRAM read latency in cycles, 1..3
//   ROW_W     bank row width in bits
//   WORD_W    byte-address width of the store port
//   MAT_S_W   matrix-slot index width
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   rFIFO_empty/REN           request FIFO status and pop
//   rFIFO_addr/mat_t/mat_s/row_s  head-of-FIFO request fields
//   bank_REN/raddr/rdata      bank SRAM read port
//   store_valid/ready/addr/data         store port
//   arr_valid/ready/type/row/data       array feed port
//   busy                      any request in flight or queued
//   perf_reads/perf_stalls    performance counters
// -----------------------------------------------------------------------------
module bank_read_responder #(
    parameter int BANK_NUM = 0,
    parameter int READ_LAT = 1,
    parameter int ROW_W    = 64,
    parameter int WORD_W   = 32,
    parameter int MAT_S_W  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 rFIFO_empty,
    output logic                 rFIFO_REN,
    input  logic [WORD_W-1:0]    rFIFO_addr,
    input  logic [1:0]           rFIFO_mat_t,
    input  logic [MAT_S_W-1:0]   rFIFO_mat_s,
    input  logic [1:0]           rFIFO_row_s,
    output logic                 bank_REN,
    output logic [MAT_S_W+1:0]   bank_raddr,
    input  logic [ROW_W-1:0]     bank_rdata,
    output logic                 store_valid,
    input  logic                 store_ready,
    output logic [WORD_W-1:0]    store_addr,
    output logic [ROW_W-1:0]     store_data,
    output logic                 arr_valid,
    input  logic                 arr_ready,
    output logic [1:0]           arr_type,
    output logic [1:0]           arr_row,
    output logic [ROW_W-1:0]     arr_data,
    output logic                 busy,
    output logic [31:0]          perf_reads,
    output logic [31:0]          perf_stalls
);

    localparam int Q_DEPTH = READ_LAT + 2;
    localparam int CNT_W   = $clog2(Q_DEPTH + 1);
    localparam int PTR_W   = $clog2(Q_DEPTH);

    localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W + 1)'(Q_DEPTH);
    localparam logic [CNT_W-1:0] QCNT_FULL  = CNT_W'(Q_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(Q_DEPTH - 1);

    // Store rows are 8 bytes apart; the sum wraps modulo 2^WORD_W.
    function automatic logic [WORD_W-1:0] row_byte_addr(
        input logic [WORD_W-1:0] base,
        input logic [1:0]        row
    );
        return base + WORD_W'({row, 3'b000});
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] qcount;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             issue;
    logic             q_push;
    logic             q_pop;

    // ------------------------------------------------------------------------
    // Issue: pop the FIFO and read the SRAM in the same cycle
    // ------------------------------------------------------------------------
    assign issue = !RST && !rFIFO_empty &&
                   (({1'b0, inflight} + {1'b0, qcount}) < CREDIT_LIM);

    assign rFIFO_REN  = issue;
    assign bank_REN   = issue;
    assign bank_raddr = issue ? {rFIFO_mat_s, rFIFO_row_s} : '0;

    // ------------------------------------------------------------------------
    // Metadata pipe, aligned with the SRAM read latency
    // ------------------------------------------------------------------------
    logic [READ_LAT-1:0] vld_p;
    logic [1:0]          mat_t_p [READ_LAT];
    logic [1:0]          row_s_p [READ_LAT];
    logic [WORD_W-1:0]   addr_p  [READ_LAT];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        mat_t_p[0] <= rFIFO_mat_t;
        row_s_p[0] <= rFIFO_row_s;
        addr_p[0]  <= rFIFO_addr;
        for (int i = 1; i < READ_LAT; i++) begin
            mat_t_p[i] <= mat_t_p[i-1];
            row_s_p[i] <= row_s_p[i-1];
            addr_p[i]  <= addr_p[i-1];
        end
    end

    // The last pipe stage coincides with bank_rdata being valid.
    assign q_push = vld_p[READ_LAT-1];

    // ------------------------------------------------------------------------
    // Circular response queue
    // ------------------------------------------------------------------------
    logic [1:0]        q_mat_t [Q_DEPTH];
    logic [1:0]        q_row_s [Q_DEPTH];
    logic [WORD_W-1:0] q_addr  [Q_DEPTH];
    logic [ROW_W-1:0]  q_data  [Q_DEPTH];

    always_ff @(posedge CLK) begin
        if (q_push) begin
            q_mat_t[tail] <= mat_t_p[READ_LAT-1];
            q_row_s[tail] <= row_s_p[READ_LAT-1];
            q_addr[tail]  <= addr_p[READ_LAT-1];
            q_data[tail]  <= bank_rdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight <= '0;
            qcount   <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= inflight + CNT_W'(issue) - CNT_W'(q_push);
            qcount   <= qcount + CNT_W'(q_push) - CNT_W'(q_pop);
            if (q_push) begin
                tail <= ptr_inc(tail);
            end
            if (q_pop) begin
                head <= ptr_inc(head);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Head routing and output hold
    // ------------------------------------------------------------------------
    logic              q_nonempty;
    logic              head_is_store;
    logic [WORD_W-1:0] st_addr_hold;
    logic [ROW_W-1:0]  st_data_hold;
    logic [1:0]        arr_type_hold;
    logic [1:0]        arr_row_hold;
    logic [ROW_W-1:0]  arr_data_hold;
    logic [WORD_W-1:0] head_st_addr;

    assign q_nonempty    = (qcount != '0);
    assign head_is_store = (q_mat_t[head] == 2'd0);
    assign head_st_addr  = row_byte_addr(q_addr[head], q_row_s[head]);

    assign store_valid = q_nonempty && head_is_store;
    assign arr_valid   = q_nonempty && !head_is_store;
    assign q_pop       = (store_valid && store_ready) || (arr_valid && arr_ready);

    // Each port remembers what it last delivered so its data outputs stay put
    // once the queue drains or the head belongs to the other port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_addr_hold  <= '0;
            st_data_hold  <= '0;
            arr_type_hold <= '0;
            arr_row_hold  <= '0;
            arr_data_hold <= '0;
        end else begin
            if (store_valid && store_ready) begin
                st_addr_hold <= head_st_addr;
                st_data_hold <= q_data[head];
            end
            if (arr_valid && arr_ready) begin
                arr_type_hold <= q_mat_t[head];
                arr_row_hold  <= q_row_s[head];
                arr_data_hold <= q_data[head];
            end
        end
    end

    assign store_addr = store_valid ? head_st_addr   : st_addr_hold;
    assign store_data = store_valid ? q_data[head]   : st_data_hold;
    assign arr_type   = arr_valid   ? q_mat_t[head]  : arr_type_hold;
    assign arr_row    = arr_valid   ? q_row_s[head]  : arr_row_hold;
    assign arr_data   = arr_valid   ? q_data[head]   : arr_data_hold;

    assign busy = (inflight != '0) || q_nonempty;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef BANK_RD_PERF_EN
    logic [31:0] perf_reads_q;
    logic [31:0] perf_stalls_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_reads_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (issue) begin
                perf_reads_q <= perf_reads_q + 32'd1;
            end
            if ((store_valid && !store_ready) || (arr_valid && !arr_ready)) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_reads  = '0;
    assign perf_stalls = '0;
`endif

    // Credit accounting must make a push into a full queue impossible.
    assert property (@(posedge CLK) disable iff (RST)
        !(q_push && !q_pop && (qcount == QCNT_FULL)));

    // Legal configuration.
    assert property (@(posedge CLK)
        (READ_LAT >= 1) && (READ_LAT <= 3) && (BANK_NUM >= 0));

endmodule

// File: tb/tb_bank_read_responder.sv
`timescale 1ns/1ps
module tb_bank_read_responder;

    localparam int READ_LAT = 1;
    localparam int ROW_W    = 64;
    localparam int WORD_W   = 32;
    localparam int MAT_S_W  = 4;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               rFIFO_empty;
    logic               rFIFO_REN;
    logic [WORD_W-1:0]  rFIFO_addr;
    logic [1:0]         rFIFO_mat_t;
    logic [MAT_S_W-1:0] rFIFO_mat_s;
    logic [1:0]         rFIFO_row_s;
    logic               bank_REN;
    logic [MAT_S_W+1:0] bank_raddr;
    logic [ROW_W-1:0]   bank_rdata;
    logic               store_valid;
    logic               store_ready = 1'b1;
    logic [WORD_W-1:0]  store_addr;
    logic [ROW_W-1:0]   store_data;
    logic               arr_valid;
    logic               arr_ready = 1'b1;
    logic [1:0]         arr_type;
    logic [1:0]         arr_row;
    logic [ROW_W-1:0]   arr_data;
    logic               busy;
    logic [31:0]        perf_reads;
    logic [31:0]        perf_stalls;

    always #5 CLK = ~CLK;

    bank_read_responder #(
        .BANK_NUM(0), .READ_LAT(READ_LAT), .ROW_W(ROW_W),
        .WORD_W(WORD_W), .MAT_S_W(MAT_S_W)
    ) dut (
        .CLK(CLK), .RST(RST),
        .rFIFO_empty(rFIFO_empty), .rFIFO_REN(rFIFO_REN),
        .rFIFO_addr(rFIFO_addr), .rFIFO_mat_t(rFIFO_mat_t),
        .rFIFO_mat_s(rFIFO_mat_s), .rFIFO_row_s(rFIFO_row_s),
        .bank_REN(bank_REN), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
        .store_valid(store_valid), .store_ready(store_ready),
        .store_addr(store_addr), .store_data(store_data),
        .arr_valid(arr_valid), .arr_ready(arr_ready),
        .arr_type(arr_type), .arr_row(arr_row), .arr_data(arr_data),
        .busy(busy), .perf_reads(perf_reads), .perf_stalls(perf_stalls)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM contents: every row is a recognisable function of its address.
    function automatic logic [ROW_W-1:0] sram_word(input logic [MAT_S_W+1:0] a);
        return {4{10'h2A5, a}};
    endfunction

    always @(posedge CLK) if (bank_REN) bank_rdata <= sram_word(bank_raddr);

    // Show-ahead request FIFO model
    typedef struct {
        logic [WORD_W-1:0]  addr;
        logic [1:0]         mat_t;
        logic [MAT_S_W-1:0] mat_s;
        logic [1:0]         row_s;
    } req_t;
    req_t fifo_mem [64];
    int   wr_ptr = 0;
    int   rd_ptr = 0;

    assign rFIFO_empty = (rd_ptr == wr_ptr);
    assign rFIFO_addr  = fifo_mem[rd_ptr].addr;
    assign rFIFO_mat_t = fifo_mem[rd_ptr].mat_t;
    assign rFIFO_mat_s = fifo_mem[rd_ptr].mat_s;
    assign rFIFO_row_s = fifo_mem[rd_ptr].row_s;

    always @(posedge CLK) if (rFIFO_REN) rd_ptr <= rd_ptr + 1;

    // Scoreboard
    typedef struct {
        logic              is_store;
        logic [WORD_W-1:0] addr;
        logic [1:0]        typ;
        logic [1:0]        row;
        logic [ROW_W-1:0]  data;
    } rsp_t;
    rsp_t               exp_q[$];
    logic [MAT_S_W+1:0] raddr_q[$];

    int                 iss_cnt = 0;
    int                 iss_cyc_log[$];
    logic [MAT_S_W+1:0] raddr_log[$];
    int                 st_cyc_log[$];
    logic [WORD_W-1:0]  st_addr_log[$];
    int                 arr_cyc_log[$];
    logic [1:0]         arr_type_log[$];
    logic [1:0]         arr_row_log[$];
    int                 stall_cnt = 0;

    task automatic push_req(input logic [1:0] mt, input logic [MAT_S_W-1:0] ms,
                            input logic [1:0] rs, input logic [WORD_W-1:0] ad);
        rsp_t               e;
        logic [MAT_S_W+1:0] ra;
        ra = {ms, rs};
        fifo_mem[wr_ptr] = '{ad, mt, ms, rs};
        wr_ptr++;
        raddr_q.push_back(ra);
        e.is_store = (mt == 2'd0);
        e.addr     = ad + {rs, 3'b000};
        e.typ      = mt;
        e.row      = rs;
        e.data     = sram_word(ra);
        exp_q.push_back(e);
    endtask

    // Monitor
    always @(negedge CLK) begin
        rsp_t               e;
        logic [MAT_S_W+1:0] r;
        if (!RST) begin
            if (bank_REN) begin
                iss_cnt++;
                iss_cyc_log.push_back(cyc);
                raddr_log.push_back(bank_raddr);
                if (raddr_q.size() == 0) begin
                    check("unexpected_issue", 64'(bank_raddr), 64'hFFFF);
                end else begin
                    r = raddr_q.pop_front();
                    check("bank_raddr", 64'(bank_raddr), 64'(r));
                end
            end
            if (store_valid && arr_valid) check("both_valid", 64'd1, 64'd0);
            if ((store_valid && !store_ready) || (arr_valid && !arr_ready)) stall_cnt++;
            if ((store_valid && store_ready) || (arr_valid && arr_ready)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_port_is_store", 64'(store_valid), 64'(e.is_store));
                    if (store_valid) begin
                        st_cyc_log.push_back(cyc);
                        st_addr_log.push_back(store_addr);
                        check("store_addr", 64'(store_addr), 64'(e.addr));
                        check("store_data", store_data, e.data);
                    end else begin
                        arr_cyc_log.push_back(cyc);
                        arr_type_log.push_back(arr_type);
                        arr_row_log.push_back(arr_row);
                        check("arr_type", 64'(arr_type), 64'(e.typ));
                        check("arr_row", 64'(arr_row), 64'(e.row));
                        check("arr_data", arr_data, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((busy || !rFIFO_empty) && n < 200);
        if (busy || !rFIFO_empty) check({name, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   i0, n0, a0, s0, flag, n;
        logic [ROW_W-1:0] d0;
        logic [1:0]       t0, r0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_store_valid", 64'(store_valid), 64'd0);
        check("rst_arr_valid",   64'(arr_valid),   64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_bank_ren",    64'(bank_REN),    64'd0);
        check("rst_store_data",  store_data,       64'd0);
        check("rst_perf_reads",  64'(perf_reads),  64'd0);
        @(posedge CLK); #1 RST = 1'b0;

        // Load-store row burst
        i0 = iss_cyc_log.size(); n0 = st_cyc_log.size();
        for (int k = 0; k < 4; k++) push_req(2'd0, 4'd2, 2'(k), 32'h1000);
        wait_idle("burst");
        check("burst_count", 64'(st_cyc_log.size() - n0), 64'd4);
        if (st_cyc_log.size() - n0 == 4 && iss_cyc_log.size() - i0 == 4) begin
            check("burst_raddr0", 64'(raddr_log[i0]),   64'h08);
            check("burst_raddr3", 64'(raddr_log[i0+3]), 64'h0B);
            check("burst_addr0",  64'(st_addr_log[n0]),   64'h1000);
            check("burst_addr1",  64'(st_addr_log[n0+1]), 64'h1008);
            check("burst_addr2",  64'(st_addr_log[n0+2]), 64'h1010);
            check("burst_addr3",  64'(st_addr_log[n0+3]), 64'h1018);
            check("burst_latency", 64'(st_cyc_log[n0] - iss_cyc_log[i0]), 64'd2);
            check("burst_back2back", 64'(st_cyc_log[n0+3] - st_cyc_log[n0]), 64'd3);
        end
        check("burst_busy_end", 64'(busy), 64'd0);

        // Weight feed
        n0 = st_cyc_log.size(); a0 = arr_cyc_log.size();
        @(posedge CLK); #1;
        for (int k = 3; k >= 0; k--) push_req(2'd2, 4'd1, 2'(k), 32'h0);
        wait_idle("weight");
        check("weight_no_store", 64'(st_cyc_log.size() - n0), 64'd0);
        check("weight_count", 64'(arr_cyc_log.size() - a0), 64'd4);
        if (arr_cyc_log.size() - a0 == 4) begin
            check("weight_type", 64'(arr_type_log[a0]),  64'd2);
            check("weight_row0", 64'(arr_row_log[a0]),   64'd3);
            check("weight_row3", 64'(arr_row_log[a0+3]), 64'd0);
        end

        // Backpressure
        @(posedge CLK); #1;
        arr_ready = 1'b0;
        i0 = iss_cnt; a0 = arr_cyc_log.size();
        for (int k = 0; k < 8; k++) push_req(2'd1, 4'd5, 2'(k % 4), 32'h0);
        repeat (4) @(negedge CLK);
        d0 = arr_data; t0 = arr_type; r0 = arr_row;
        flag = 0;
        repeat (6) begin
            @(negedge CLK);
            if (arr_data !== d0 || arr_type !== t0 || arr_row !== r0 || !arr_valid) flag = 1;
        end
        check("bp_issue_limit", 64'(iss_cnt - i0), 64'd3);
        check("bp_stable", 64'(flag), 64'd0);
        check("bp_head_row", 64'(arr_row), 64'd0);
        check("bp_busy", 64'(busy), 64'd1);
        @(posedge CLK); #1 arr_ready = 1'b1;
        wait_idle("bp");
        check("bp_delivered", 64'(arr_cyc_log.size() - a0), 64'd8);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Mixed ordering
        @(posedge CLK); #1;
        store_ready = 1'b0;
        n0 = st_cyc_log.size(); a0 = arr_cyc_log.size();
        push_req(2'd0, 4'd3, 2'd1, 32'h2000);
        push_req(2'd3, 4'd3, 2'd2, 32'h0);
        flag = 0;
        repeat (5) begin
            @(negedge CLK);
            if (arr_valid) flag = 1;
        end
        check("mix_arr_blocked", 64'(flag), 64'd0);
        check("mix_store_waiting", 64'(store_valid), 64'd1);
        @(posedge CLK); #1 store_ready = 1'b1;
        wait_idle("mix");
        if (st_cyc_log.size() - n0 == 1 && arr_cyc_log.size() - a0 == 1) begin
            check("mix_store_addr", 64'(st_addr_log[n0]), 64'h2008);
            check("mix_psum_type", 64'(arr_type_log[a0]), 64'd3);
            check("mix_order", 64'(arr_cyc_log[a0] > st_cyc_log[n0]), 64'd1);
        end else begin
            check("mix_count", 64'(st_cyc_log.size() - n0 + arr_cyc_log.size() - a0), 64'd2);
        end

        // Reset mid-operation
        @(posedge CLK); #1;
        store_ready = 1'b0; arr_ready = 1'b0;
        i0 = iss_cnt;
        s0 = st_cyc_log.size() + arr_cyc_log.size();
        push_req(2'd1, 4'd7, 2'd0, 32'h0);
        push_req(2'd1, 4'd7, 2'd1, 32'h0);
        n = 0;
        while (iss_cnt - i0 < 2 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("rstmid_issued", 64'(iss_cnt - i0), 64'd2);
        @(posedge CLK); #2;
        check("rstmid_busy_before", 64'(busy), 64'd1);
        RST = 1'b1;
        #1;
        check("rstmid_store_valid", 64'(store_valid), 64'd0);
        check("rstmid_arr_valid",   64'(arr_valid),   64'd0);
        check("rstmid_busy",        64'(busy),        64'd0);
        exp_q.delete();
        raddr_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        store_ready = 1'b1; arr_ready = 1'b1;
        repeat (6) @(negedge CLK);
        check("rstmid_no_stale", 64'(st_cyc_log.size() + arr_cyc_log.size() - s0), 64'd0);
        check("rstmid_busy_after", 64'(busy), 64'd0);

        // Performance counters
        @(posedge CLK); #1;
        arr_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_req(2'd1, 4'd4, 2'(k % 4), 32'h0);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!arr_valid && n < 20);
        check("perf_first_valid", 64'(arr_valid), 64'd1);
        repeat (3) @(posedge CLK);
        #1 arr_ready = 1'b1;
        wait_idle("perf");
`ifdef BANK_RD_PERF_EN
        check("perf_reads",  64'(perf_reads),  64'd5);
        check("perf_stalls", 64'(perf_stalls), 64'd3);
`else
        check("perf_reads_off",  64'(perf_reads),  64'd0);
        check("perf_stalls_off", 64'(perf_stalls), 64'd0);
`endif
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
